// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared opcodes, operand-select encodings, FSM states and shadow record for hazard_fwd_ctrl.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hazard_fwd_ctrl_pkg;

  // RV32 major opcodes the hazard logic needs to tell apart
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 bit that marks the CSR-immediate forms (rs1 field is a zimm)
  localparam int FNC3_CSR_IMM_BIT = 2;

  // Operand source selects for s2
  localparam logic [1:0] SEL_RF  = 2'b10;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } fsm_t;

  // Fields shadowed for each of s2 and s3
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } shadow_t;

  function automatic logic [1:0] fwd_sel(input logic hit, input logic is_load);
    if (!hit) return SEL_RF;
    return is_load ? SEL_LD : SEL_ALU;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Field/usage decode of one instruction word for hazard detection.
// Latency: purely combinational.
// Backpressure: none.
module hazard_decode
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_reg_write,
  output logic        o_is_load
);

  logic [6:0] w_opc;
  logic       w_unused;

  assign w_opc    = i_instr[6:0];
  assign o_rd     = i_instr[11:7];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];
  // funct7 and the low funct3 bits never affect hazards
  assign w_unused = ^{i_instr[31:25], i_instr[13:12]};

  // Classify which register fields are real sources / destinations
  always_comb begin
    o_uses_rs1  = 1'b1;
    o_uses_rs2  = 1'b0;
    o_reg_write = 1'b1;
    o_is_load   = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: o_uses_rs1 = 1'b0;
      OPC_SYSTEM: o_uses_rs1 = ~i_instr[12 + FNC3_CSR_IMM_BIT];
      OPC_OP:     o_uses_rs2 = 1'b1;
      OPC_STORE, OPC_BRANCH: begin
        o_uses_rs2  = 1'b1;
        o_reg_write = 1'b0;
      end
      OPC_LOAD:   o_is_load = 1'b1;
      default: ;
    endcase
    // x0 is never a real destination
    if (o_rd == 5'd0) o_reg_write = 1'b0;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Operand-forward selects plus load-use stall / redirect flush control for a 3-stage core.
// Latency: selects registered one cycle (valid with consumer in s2); stall/bubble/flush combinational.
// Backpressure: stall_ext freezes all state and holds s1; load-use inserts LOAD_USE_STALL bubbles.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction_s1,
  input  logic              redirect_s2,
  input  logic              stall_ext,
  output logic [1:0]        rs1_sel,
  output logic [1:0]        rs2_sel,
  output logic              stall_s1,
  output logic              bubble_s2,
  output logic              flush_s1,
  output logic              valid_s2,
  output logic              valid_s3,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  // Bubble counter only needs to hold LOAD_USE_STALL-1
  localparam int CNT_W = (LOAD_USE_STALL > 2) ? $clog2(LOAD_USE_STALL) : 1;
  localparam logic [CNT_W-1:0] CNT_ENTRY =
    CNT_W'((LOAD_USE_STALL > 0) ? LOAD_USE_STALL - 1 : 0);

  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic              w_uses_rs1, w_uses_rs2, w_reg_write, w_is_load;
  logic              w_hit1, w_hit2, w_load_hit;
  logic [1:0]        w_sel1, w_sel2;
  shadow_t           w_s1;
  fsm_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_lu_stall, w_flush, w_stall;
  shadow_t           r_s2, r_s3;
  logic [1:0]        r_rs1_sel, r_rs2_sel;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;
  logic              w_unused_s3;

  hazard_decode u_dec (
    .i_instr     (instruction_s1),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_rd        (w_rd),
    .o_uses_rs1  (w_uses_rs1),
    .o_uses_rs2  (w_uses_rs2),
    .o_reg_write (w_reg_write),
    .o_is_load   (w_is_load)
  );

  assign w_s1 = '{vld: 1'b1, rd: w_rd, reg_write: w_reg_write, is_load: w_is_load};

  // Only s2 producers matter: s3 results reach the regfile before s1 reads it
  assign w_hit1 = r_s2.vld & r_s2.reg_write & (r_s2.rd == w_rs1) & w_uses_rs1 & (w_rs1 != 5'd0);
  assign w_hit2 = r_s2.vld & r_s2.reg_write & (r_s2.rd == w_rs2) & w_uses_rs2 & (w_rs2 != 5'd0);
  assign w_load_hit = (w_hit1 | w_hit2) & r_s2.is_load;
  assign w_sel1 = fwd_sel(w_hit1, r_s2.is_load);
  assign w_sel2 = fwd_sel(w_hit2, r_s2.is_load);

  // FSM next state and pipe controls; priority rst > stall_ext > redirect > load-use
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lu_stall  = 1'b0;
    w_flush     = 1'b0;
    w_stall     = 1'b0;
    if (rst) begin
      w_state_nxt = ST_RUN;
    end else if (stall_ext) begin
      w_stall = 1'b1;
    end else if (redirect_s2) begin
      w_flush     = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_LSTALL) begin
      if (r_cnt != '0) begin
        w_lu_stall = 1'b1;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else if ((LOAD_USE_STALL > 0) && w_load_hit) begin
      w_lu_stall  = 1'b1;
      w_state_nxt = ST_LSTALL;
      w_cnt_nxt   = CNT_ENTRY;
    end
    w_stall = w_stall | w_lu_stall;
  end

  assign stall_s1  = w_stall;
  assign bubble_s2 = w_lu_stall;
  assign flush_s1  = w_flush;

  // Shadow pipe, registered selects, FSM state and perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_rs1_sel   <= SEL_RF;
      r_rs2_sel   <= SEL_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!stall_ext) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s3    <= r_s2;
      if (w_lu_stall) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_flush)    r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      if (w_lu_stall || w_flush) begin
        // s2 receives a NOP; its selects are don't-care, park them on the regfile
        r_s2      <= '0;
        r_rs1_sel <= SEL_RF;
        r_rs2_sel <= SEL_RF;
      end else begin
        r_s2      <= w_s1;
        r_rs1_sel <= w_sel1;
        r_rs2_sel <= w_sel2;
      end
    end
  end

  assign rs1_sel     = r_rs1_sel;
  assign rs2_sel     = r_rs2_sel;
  assign valid_s2    = r_s2.vld;
  assign valid_s3    = r_s3.vld;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign w_unused_s3 = ^{r_s3.rd, r_s3.reg_write, r_s3.is_load};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: three instances (LOAD_USE_STALL 1/0/2, last with 3-bit counters).
// Each instance has its own s1 fetch emulation driven from a shared program and an abstract pipeline model.
// Directed scenarios first, then randomized instructions/redirects/external stalls.
module tb_hazard_fwd_ctrl;

  localparam int N = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redir, ext;
  logic [31:0] ins [N];
  logic [1:0]  o_rs1 [N];
  logic [1:0]  o_rs2 [N];
  logic        o_st [N];
  logic        o_bu [N];
  logic        o_fl [N];
  logic        o_v2 [N];
  logic        o_v3 [N];
  logic [31:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [2:0]  scnt2, fcnt2;

  int total = 0;
  int bad   = 0;

  hazard_fwd_ctrl #(.LOAD_USE_STALL(1), .PERF_W(32)) u0 (
    .clk(clk), .rst(rst), .instruction_s1(ins[0]), .redirect_s2(redir), .stall_ext(ext),
    .rs1_sel(o_rs1[0]), .rs2_sel(o_rs2[0]), .stall_s1(o_st[0]), .bubble_s2(o_bu[0]),
    .flush_s1(o_fl[0]), .valid_s2(o_v2[0]), .valid_s3(o_v3[0]),
    .stall_cnt(scnt0), .flush_cnt(fcnt0));

  hazard_fwd_ctrl #(.LOAD_USE_STALL(0), .PERF_W(32)) u1 (
    .clk(clk), .rst(rst), .instruction_s1(ins[1]), .redirect_s2(redir), .stall_ext(ext),
    .rs1_sel(o_rs1[1]), .rs2_sel(o_rs2[1]), .stall_s1(o_st[1]), .bubble_s2(o_bu[1]),
    .flush_s1(o_fl[1]), .valid_s2(o_v2[1]), .valid_s3(o_v3[1]),
    .stall_cnt(scnt1), .flush_cnt(fcnt1));

  hazard_fwd_ctrl #(.LOAD_USE_STALL(2), .PERF_W(3)) u2 (
    .clk(clk), .rst(rst), .instruction_s1(ins[2]), .redirect_s2(redir), .stall_ext(ext),
    .rs1_sel(o_rs1[2]), .rs2_sel(o_rs2[2]), .stall_s1(o_st[2]), .bubble_s2(o_bu[2]),
    .flush_s1(o_fl[2]), .valid_s2(o_v2[2]), .valid_s3(o_v3[2]),
    .stall_cnt(scnt2), .flush_cnt(fcnt2));

  function automatic int lus(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 2;
  endfunction

  function automatic logic [63:0] cmask(input int k);
    return (k == 2) ? 64'h7 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] get_scnt(input int k);
    return (k == 0) ? {32'd0, scnt0} : (k == 1) ? {32'd0, scnt1} : {61'd0, scnt2};
  endfunction

  function automatic logic [63:0] get_fcnt(input int k);
    return (k == 0) ? {32'd0, fcnt0} : (k == 1) ? {32'd0, fcnt1} : {61'd0, fcnt2};
  endfunction

  // ---- instruction semantics, straight from the ISA rules ----
  function automatic logic uses1(input logic [31:0] i);
    case (i[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
      7'b1110011: return !i[14];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic uses2(input logic [31:0] i);
    return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0100011) || (i[6:0] == 7'b1100011);
  endfunction

  function automatic logic writes(input logic [31:0] i);
    return (i[6:0] != 7'b0100011) && (i[6:0] != 7'b1100011) && (i[11:7] != 5'd0);
  endfunction

  function automatic logic is_ld(input logic [31:0] i);
    return i[6:0] == 7'b0000011;
  endfunction

  // operand source the consumer c needs when producer p (valid v2) is one stage ahead
  function automatic logic [1:0] fsel(input logic v2, input logic [31:0] p,
                                      input logic [31:0] c, input logic second);
    logic [4:0] rs;
    logic       u;
    rs = second ? c[24:20] : c[19:15];
    u  = second ? uses2(c) : uses1(c);
    if (v2 && writes(p) && u && rs != 5'd0 && p[11:7] == rs) return is_ld(p) ? 2'b01 : 2'b00;
    return 2'b10;
  endfunction

  // ---- encoders ----
  function automatic logic [31:0] e_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
    return {imm, a, 3'd0, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] a);
    return {12'd0, a, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] e_sw(input logic [4:0] b, input logic [4:0] a);
    return {7'd0, b, a, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: return e_add(a, b, c);
      1: return e_addi(a, b, 12'h005);
      2: return e_lw(a, b);
      3: return e_sw(b, c);
      4: return e_beq(b, c);
      5: return {20'h12345, a, 7'b0110111};
      6: return {20'h00010, a, 7'b0010111};
      7: return {20'h00000, a, 7'b1101111};
      8: return {12'h300, b, 3'b001, a, 7'b1110011};
      default: return {12'h300, b, 3'b101, a, 7'b1110011};
    endcase
  endfunction

  // ---- reference model state ----
  logic [31:0] prog [$];
  int          pc [N];
  logic [31:0] cur [N];
  logic [31:0] m_s2 [N];
  logic        m_v2 [N];
  logic        m_v3 [N];
  logic [1:0]  m_sel1 [N];
  logic [1:0]  m_sel2 [N];
  int          m_left [N];
  logic [63:0] m_scnt [N];
  logic [63:0] m_fcnt [N];

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%0h want=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < N; k++) begin
      pc[k] = 0; m_s2[k] = NOP; m_v2[k] = 1'b0; m_v3[k] = 1'b0;
      m_sel1[k] = 2'b10; m_sel2[k] = 2'b10; m_left[k] = 0;
      m_scnt[k] = 64'd0; m_fcnt[k] = 64'd0;
    end
  endtask

  // One clock: present inputs, check comb controls, clock, check registered state
  task automatic step(input logic r, input logic rd_in, input logic ex);
    logic e_st [N];
    logic e_bu [N];
    logic e_fl [N];
    logic [1:0] n1, n2;
    @(negedge clk);
    rst = r; redir = rd_in; ext = ex;
    for (int k = 0; k < N; k++) begin
      cur[k] = (pc[k] < prog.size()) ? prog[pc[k]] : NOP;
      ins[k] = cur[k];
    end
    #1;
    for (int k = 0; k < N; k++) begin
      e_st[k] = 1'b0; e_bu[k] = 1'b0; e_fl[k] = 1'b0;
      if (r) begin
      end else if (ex) e_st[k] = 1'b1;
      else if (rd_in) e_fl[k] = 1'b1;
      else if (m_left[k] > 0) begin e_st[k] = 1'b1; e_bu[k] = 1'b1; end
      else if (lus(k) > 0 &&
               (fsel(m_v2[k], m_s2[k], cur[k], 1'b0) == 2'b01 ||
                fsel(m_v2[k], m_s2[k], cur[k], 1'b1) == 2'b01)) begin
        e_st[k] = 1'b1; e_bu[k] = 1'b1;
      end
      chk("stall_s1", k, 64'(o_st[k]), 64'(e_st[k]));
      chk("bubble_s2", k, 64'(o_bu[k]), 64'(e_bu[k]));
      chk("flush_s1", k, 64'(o_fl[k]), 64'(e_fl[k]));
    end
    @(posedge clk);
    #1;
    if (r) mreset();
    else if (!ex) begin
      for (int k = 0; k < N; k++) begin
        if (e_bu[k]) m_scnt[k] += 64'd1;
        if (e_fl[k]) m_fcnt[k] += 64'd1;
        m_v3[k] = m_v2[k];
        if (e_bu[k]) begin
          m_v2[k] = 1'b0; m_sel1[k] = 2'b10; m_sel2[k] = 2'b10;
          m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : lus(k) - 1;
        end else begin
          n1 = fsel(m_v2[k], m_s2[k], cur[k], 1'b0);
          n2 = fsel(m_v2[k], m_s2[k], cur[k], 1'b1);
          m_v2[k] = !e_fl[k]; m_s2[k] = cur[k];
          m_sel1[k] = e_fl[k] ? 2'b10 : n1;
          m_sel2[k] = e_fl[k] ? 2'b10 : n2;
          m_left[k] = 0;
          pc[k]++;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      chk("rs1_sel", k, 64'(o_rs1[k]), 64'(m_sel1[k]));
      chk("rs2_sel", k, 64'(o_rs2[k]), 64'(m_sel2[k]));
      chk("valid_s2", k, 64'(o_v2[k]), 64'(m_v2[k]));
      chk("valid_s3", k, 64'(o_v3[k]), 64'(m_v3[k]));
      chk("stall_cnt", k, get_scnt(k), m_scnt[k] & cmask(k));
      chk("flush_cnt", k, get_fcnt(k), m_fcnt[k] & cmask(k));
    end
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; ext = 1'b0;
    for (int k = 0; k < N; k++) ins[k] = NOP;
    mreset();

    // forwarding from ALU and load producers
    prog.delete();
    prog.push_back(e_addi(5'd5, 5'd0, 12'd7));
    prog.push_back(e_add(5'd6, 5'd5, 5'd5));
    prog.push_back(e_lw(5'd5, 5'd1));
    prog.push_back(e_add(5'd6, 5'd5, 5'd0));
    prog.push_back(NOP);
    prog.push_back(NOP);
    step(1, 0, 0); step(1, 0, 0);
    for (int k = 0; k < N; k++) chk("reset_sel", k, 64'(o_rs1[k]), 64'(2'b10));
    step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < N; k++) begin
      chk("alu_fwd_rs1", k, 64'(o_rs1[k]), 64'(2'b00));
      chk("alu_fwd_rs2", k, 64'(o_rs2[k]), 64'(2'b00));
    end
    step(0, 0, 0); step(0, 0, 0);
    chk("ld_fwd_rs1", 1, 64'(o_rs1[1]), 64'(2'b01));
    chk("ld_fwd_rs2", 1, 64'(o_rs2[1]), 64'(2'b10));
    chk("ld_nostall_cnt", 1, get_scnt(1), 64'd0);
    chk("ld_stall_cnt", 0, get_scnt(0), 64'd1);
    step(0, 0, 0);
    chk("ld_after_rs1", 0, 64'(o_rs1[0]), 64'(2'b10));
    chk("ld_after_v2", 0, 64'(o_v2[0]), 64'd1);
    chk("ld2_stall_cnt", 2, get_scnt(2), 64'd2);
    step(0, 0, 0);

    // x0 never forwards
    prog.delete();
    prog.push_back(e_addi(5'd0, 5'd0, 12'd1));
    prog.push_back(e_add(5'd6, 5'd0, 5'd0));
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int k = 0; k < N; k++) chk("x0_rs1", k, 64'(o_rs1[k]), 64'(2'b10));

    // taken branch kills the x5 producer in s1
    prog.delete();
    prog.push_back(e_beq(5'd0, 5'd0));
    prog.push_back(e_addi(5'd5, 5'd0, 12'd1));
    prog.push_back(e_add(5'd6, 5'd5, 5'd5));
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    for (int k = 0; k < N; k++) begin
      chk("flush_v2", k, 64'(o_v2[k]), 64'd0);
      chk("flush_cnt1", k, get_fcnt(k), 64'd1);
    end
    step(0, 0, 0);
    for (int k = 0; k < N; k++) chk("post_flush_rs1", k, 64'(o_rs1[k]), 64'(2'b10));

    // external stall while a load-use hazard is pending
    prog.delete();
    prog.push_back(e_lw(5'd5, 5'd1));
    prog.push_back(e_add(5'd6, 5'd5, 5'd0));
    step(1, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      chk("ext_v2", 0, 64'(o_v2[0]), 64'd1);
      chk("ext_scnt", 0, get_scnt(0), 64'd0);
    end
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // reset while in the load-use stall
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    for (int k = 0; k < N; k++) begin
      chk("rst_ls_v2", k, 64'(o_v2[k]), 64'd0);
      chk("rst_ls_scnt", k, get_scnt(k), 64'd0);
    end
    step(0, 0, 0); step(0, 0, 0);

    // randomized traffic
    prog.delete();
    for (int i = 0; i < 600; i++) prog.push_back(rnd_ins());
    step(1, 0, 0);
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
